// File: rtl/jtag_spi_pkg.sv
// Shared constants for the JTAG user-chain to SPI bridge: FSM state codes and header layout.
// The header is MSB first: magic, chip-select index, payload bit length.
package jtag_spi_pkg;

    localparam int HDR_MAGIC_W = 16;
    localparam int HDR_CS_W    = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t HUNT  = 2'd1;
    localparam state_t XFER  = 2'd2;
    localparam state_t DRAIN = 2'd3;

    function automatic int hdr_width(input int len_w);
        return HDR_MAGIC_W + HDR_CS_W + len_w;
    endfunction

    function automatic int hdr_magic_lsb(input int len_w);
        return HDR_CS_W + len_w;
    endfunction

    function automatic int hdr_cs_lsb(input int len_w);
        return len_w;
    endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Two-flop synchroniser for one asynchronous BSCAN signal, plus rise/fall strobes
// taken between the synchronised level and a third history flop.
module jtag_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], din};
        end
    end

    assign level = sync_reg[1];
    assign rise  = sync_reg[1] & ~sync_reg[2];
    assign fall  = ~sync_reg[1] & sync_reg[2];

endmodule

// File: rtl/jtag_spi_bridge.sv
// JTAG user-chain to SPI bridge running entirely on clk; DRCK is oversampled, not used as a clock.
// Optional JTAG_SPI_TIMEOUT_EN aborts a transfer after TIMEOUT idle clk cycles without DRCK edges.
module jtag_spi_bridge
    import jtag_spi_pkg::*;
#(
    parameter int          NUM_CS    = 2,
    parameter int          LEN_W     = 16,
    parameter logic [15:0] MAGIC     = 16'h59A6,
    parameter int          TDO_DELAY = 1,
    parameter int          TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jtag_drck,
    input  logic              jtag_tdi,
    input  logic              jtag_sel,
    input  logic              jtag_shift,
    input  logic              jtag_capture,
    input  logic              jtag_update,
    input  logic              jtag_reset,
    output logic              jtag_tdo,
    input  logic              spi_miso,
    output logic              spi_mosi,
    output logic              spi_sck,
    output logic [NUM_CS-1:0] spi_cs_n,
    output logic              busy,
    output logic              err_cs
);

    localparam int HDR_W     = hdr_width(LEN_W);
    localparam int MAGIC_LSB = hdr_magic_lsb(LEN_W);
    localparam int CS_LSB    = hdr_cs_lsb(LEN_W);
    localparam int N_SYNC    = 7;
    localparam logic [HDR_CS_W-1:0] NUM_CS_B = HDR_CS_W'(NUM_CS);

    logic [N_SYNC-1:0] pin_vec, lvl_vec, rise_vec, fall_vec;

    assign pin_vec = {jtag_reset, jtag_update, jtag_capture, jtag_shift,
                      jtag_sel, jtag_tdi, jtag_drck};

    for (genvar gi = 0; gi < N_SYNC; gi++) begin : g_sync
        jtag_sync_edge u_sync (
            .clk   (clk),
            .reset (reset),
            .din   (pin_vec[gi]),
            .level (lvl_vec[gi]),
            .rise  (rise_vec[gi]),
            .fall  (fall_vec[gi])
        );
    end

    // Only DRCK needs edge strobes; the other signals are consumed as levels.
    logic unused_sync;
    assign unused_sync = ^{rise_vec[N_SYNC-1:1], fall_vec[N_SYNC-1:1], lvl_vec[0]};

    logic drck_rise, drck_fall, tdi_s, sel_s, shift_s, abort;
    assign drck_rise = rise_vec[0];
    assign drck_fall = fall_vec[0];
    assign tdi_s     = lvl_vec[1];
    assign sel_s     = lvl_vec[2];
    assign shift_s   = lvl_vec[3];
    assign abort     = lvl_vec[4] | lvl_vec[5] | lvl_vec[6] | ~sel_s;

    state_t               state_reg;
    logic [HDR_W-1:0]     hdr_reg;
    logic [LEN_W-1:0]     len_reg;
    logic [NUM_CS-1:0]    cs_n_reg;
    logic [TDO_DELAY-1:0] tdo_reg;
    logic                 sck_reg, sck_pend_reg, mosi_reg, err_cs_reg;

    logic [HDR_W-1:0]     hdr_next;
    logic [HDR_CS_W-1:0]  hdr_cs;
    logic [LEN_W-1:0]     hdr_len, len_next;
    logic [NUM_CS-1:0]    cs_onehot;
    logic [TDO_DELAY:0]   tdo_ext;
    logic                 hdr_match;

    assign hdr_next  = {hdr_reg[HDR_W-2:0], tdi_s};
    assign hdr_match = (hdr_next[MAGIC_LSB +: HDR_MAGIC_W] == MAGIC);
    assign hdr_cs    = hdr_next[CS_LSB +: HDR_CS_W];
    assign hdr_len   = hdr_next[LEN_W-1:0];
    assign len_next  = (len_reg == '0) ? '0 : len_reg - LEN_W'(1);
    assign tdo_ext   = {tdo_reg, spi_miso};

    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
        assign cs_onehot[gi] = (hdr_cs == HDR_CS_W'(gi));
    end

`ifdef JTAG_SPI_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_reg;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            hdr_reg      <= '0;
            len_reg      <= '0;
            cs_n_reg     <= '1;
            tdo_reg      <= '0;
            sck_reg      <= 1'b0;
            sck_pend_reg <= 1'b0;
            mosi_reg     <= 1'b0;
            err_cs_reg   <= 1'b0;
`ifdef JTAG_SPI_TIMEOUT_EN
            to_cnt_reg   <= '0;
`endif
        end else if (abort) begin
            state_reg    <= IDLE;
            hdr_reg      <= '0;
            cs_n_reg     <= '1;
            tdo_reg      <= '0;
            sck_reg      <= 1'b0;
            sck_pend_reg <= 1'b0;
            mosi_reg     <= 1'b0;
`ifdef JTAG_SPI_TIMEOUT_EN
            to_cnt_reg   <= '0;
`endif
        end else begin
`ifdef JTAG_SPI_TIMEOUT_EN
            if (state_reg != XFER) to_cnt_reg <= '0;
`endif
            case (state_reg)
                IDLE: if (shift_s) state_reg <= HUNT;
                HUNT: begin
                    if (drck_rise && shift_s) begin
                        hdr_reg <= hdr_next;
                        if (hdr_match) begin
                            if (hdr_cs >= NUM_CS_B) begin
                                err_cs_reg <= 1'b1;
                                state_reg  <= DRAIN;
                            end else if (hdr_len == '0) begin
                                state_reg  <= DRAIN;
                            end else begin
                                len_reg    <= hdr_len;
                                cs_n_reg   <= ~cs_onehot;
                                state_reg  <= XFER;
                            end
                        end
                    end
                end
                XFER: begin
                    // MOSI is set up one clk before SCK rises so the slave sees a settled bit.
                    if (drck_rise && shift_s) begin
                        mosi_reg     <= tdi_s;
                        sck_pend_reg <= 1'b1;
                    end else if (sck_pend_reg) begin
                        sck_reg      <= 1'b1;
                        sck_pend_reg <= 1'b0;
                    end else if (drck_fall && sck_reg) begin
                        sck_reg <= 1'b0;
                        tdo_reg <= tdo_ext[TDO_DELAY-1:0];
                        len_reg <= len_next;
                        if (len_next == '0) begin
                            cs_n_reg  <= '1;
                            state_reg <= DRAIN;
                        end
                    end
`ifdef JTAG_SPI_TIMEOUT_EN
                    if (drck_rise || drck_fall) begin
                        to_cnt_reg <= '0;
                    end else if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
                        cs_n_reg     <= '1;
                        sck_reg      <= 1'b0;
                        sck_pend_reg <= 1'b0;
                        state_reg    <= DRAIN;
                        to_cnt_reg   <= '0;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
`endif
                end
                DRAIN: begin
                    sck_reg      <= 1'b0;
                    sck_pend_reg <= 1'b0;
                    cs_n_reg     <= '1;
                    mosi_reg     <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign jtag_tdo = tdo_reg[TDO_DELAY-1];
    assign spi_mosi = mosi_reg;
    assign spi_sck  = sck_reg;
    assign spi_cs_n = cs_n_reg;
    assign busy     = (state_reg == XFER);
    assign err_cs   = err_cs_reg;

endmodule
